// File: rtl/stopwatch_ctrl.sv
// Count-up stopwatch, 00:00.00 to 99:59.99, driving eight 7-segment digit inputs.
// Optional build macro LEADING_ZERO_BLANK_EN blanks d8 while the minute tens digit is 0.
module stopwatch_ctrl #(
    parameter int unsigned TICK_COUNT = 500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       lap,
    output logic       running,
    output logic       lap_hold,
    output logic       ovf,
    output logic [6:0] min_out,
    output logic [6:0] sec_out,
    output logic [6:0] cs_out,
    output logic [5:0] d1,
    output logic [5:0] d2,
    output logic [5:0] d3,
    output logic [5:0] d4,
    output logic [5:0] d5,
    output logic [5:0] d6,
    output logic [5:0] d7,
    output logic [5:0] d8
);

    localparam int unsigned PW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_COUNT - 1);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [6:0]    min_q, min_d, sec_q, sec_d, cs_q, cs_d;
    logic          lap_hold_q, lap_hold_d;
    logic          ovf_q, ovf_d;
    logic          start_q, stop_q, pause_q, lap_btn_q;
    logic [6:0]    snap_min_q, snap_sec_q, snap_cs_q;

    logic stop_cmd, start_cmd, pause_cmd, lap_cmd;
    logic tick, at_max, clear;

    // One command per edge, highest priority wins.
    assign stop_cmd  = stop & ~stop_q;
    assign start_cmd = start & ~start_q & ~stop_cmd;
    assign pause_cmd = pause & ~pause_q & ~stop_cmd & ~start_cmd;
    assign lap_cmd   = lap & ~lap_btn_q & ~stop_cmd & ~start_cmd & ~pause_cmd;

    assign tick   = (state_q == ST_RUN) && (presc_q == PRESC_MAX);
    assign at_max = (min_q == 7'd99) && (sec_q == 7'd59) && (cs_q == 7'd99);

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        min_d      = min_q;
        sec_d      = sec_q;
        cs_d       = cs_q;
        lap_hold_d = lap_hold_q;
        ovf_d      = ovf_q;
        clear      = 1'b0;

        if (state_q == ST_RUN) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        if (tick) begin
            if (at_max) begin
                ovf_d   = 1'b1;
                state_d = ST_PAUSE;
            end else if (cs_q == 7'd99) begin
                cs_d = '0;
                if (sec_q == 7'd59) begin
                    sec_d = '0;
                    min_d = min_q + 7'd1;
                end else begin
                    sec_d = sec_q + 7'd1;
                end
            end else begin
                cs_d = cs_q + 7'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start_cmd) begin
                    clear   = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop_cmd) begin
                    clear   = 1'b1;
                    state_d = ST_IDLE;
                end else if (pause_cmd) begin
                    state_d = ST_PAUSE;
                end else if (lap_cmd) begin
                    lap_hold_d = ~lap_hold_q;
                end
            end
            ST_PAUSE: begin
                if (stop_cmd) begin
                    clear   = 1'b1;
                    state_d = ST_IDLE;
                end else if ((start_cmd || pause_cmd) && !ovf_q) begin
                    state_d = ST_RUN;
                end else if (lap_cmd && lap_hold_q) begin
                    lap_hold_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (clear) begin
            presc_d    = '0;
            min_d      = '0;
            sec_d      = '0;
            cs_d       = '0;
            ovf_d      = 1'b0;
            lap_hold_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            min_q      <= '0;
            sec_q      <= '0;
            cs_q       <= '0;
            lap_hold_q <= 1'b0;
            ovf_q      <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            pause_q    <= 1'b0;
            lap_btn_q  <= 1'b0;
            snap_min_q <= '0;
            snap_sec_q <= '0;
            snap_cs_q  <= '0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            cs_q       <= cs_d;
            lap_hold_q <= lap_hold_d;
            ovf_q      <= ovf_d;
            start_q    <= start;
            stop_q     <= stop;
            pause_q    <= pause;
            lap_btn_q  <= lap;
            if (!lap_hold_q) begin
                snap_min_q <= min_q;
                snap_sec_q <= sec_q;
                snap_cs_q  <= cs_q;
            end
        end
    end

    function automatic logic [3:0] tens_of(input logic [6:0] v);
        logic [6:0] t;
        t = v / 7'd10;
        return t[3:0];
    endfunction

    function automatic logic [3:0] units_of(input logic [6:0] v);
        logic [6:0] t;
        t = v % 7'd10;
        return t[3:0];
    endfunction

    logic [3:0] min_tens;
    logic       d8_en;

    assign min_tens = tens_of(snap_min_q);

`ifdef LEADING_ZERO_BLANK_EN
    assign d8_en = (min_tens != 4'd0);
`else
    assign d8_en = 1'b1;
`endif

    // Digit format is {en, value, dp}; points sit after minutes and seconds.
    always_comb begin
        d8 = {d8_en, min_tens, 1'b0};
        d7 = {1'b1, units_of(snap_min_q), 1'b1};
        d6 = {1'b1, tens_of(snap_sec_q), 1'b0};
        d5 = {1'b1, units_of(snap_sec_q), 1'b1};
        d4 = {1'b1, tens_of(snap_cs_q), 1'b0};
        d3 = {1'b1, units_of(snap_cs_q), 1'b0};
        d2 = 6'b0;
        d1 = 6'b0;
    end

    assign running  = (state_q == ST_RUN);
    assign lap_hold = lap_hold_q;
    assign ovf      = ovf_q;
    assign min_out  = min_q;
    assign sec_out  = sec_q;
    assign cs_out   = cs_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random buttons against an elapsed-time model.
module tb_stopwatch_ctrl;

    localparam int unsigned TICK = 4;
    localparam int MAXCS = 599999;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0, stop = 1'b0, pause = 1'b0, lap = 1'b0;
    logic running, lap_hold, ovf;
    logic [6:0] min_out, sec_out, cs_out;
    logic [5:0] d1, d2, d3, d4, d5, d6, d7, d8;

    int total = 0;
    int bad = 0;

    stopwatch_ctrl #(.TICK_COUNT(TICK)) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop), .pause(pause), .lap(lap),
        .running(running), .lap_hold(lap_hold), .ovf(ovf),
        .min_out(min_out), .sec_out(sec_out), .cs_out(cs_out),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7), .d8(d8)
    );

    always #5 clock = ~clock;

    // Model: elapsed time = clocks spent running / TICK, saturated at 99:59.99.
    typedef enum int {MIdle, MRun, MPause} mstate_t;
    mstate_t m_state;
    longint  m_run;
    bit      m_lap, m_ovf;
    int      m_snap;
    bit      p_start, p_stop, p_pause, p_lap;

    function automatic int elapsed();
        longint e;
        e = m_run / TICK;
        return (e > MAXCS) ? MAXCS : int'(e);
    endfunction

    function automatic void model_reset();
        m_state = MIdle; m_run = 0; m_lap = 0; m_ovf = 0; m_snap = 0;
        p_start = 0; p_stop = 0; p_pause = 0; p_lap = 0;
    endfunction

    function automatic void model_clear();
        m_state = MIdle; m_run = 0; m_lap = 0; m_ovf = 0;
    endfunction

    function automatic void model_step();
        int cmd;
        mstate_t old;
        if (stop && !p_stop) cmd = 1;
        else if (start && !p_start) cmd = 2;
        else if (pause && !p_pause) cmd = 3;
        else if (lap && !p_lap) cmd = 4;
        else cmd = 0;
        p_start = start; p_stop = stop; p_pause = pause; p_lap = lap;
        old = m_state;
        if (!m_lap) m_snap = elapsed();
        if (old == MRun) begin
            m_run++;
            if ((m_run % TICK) == 0 && (m_run / TICK) > MAXCS) begin
                m_ovf = 1; m_state = MPause;
            end
        end
        case (old)
            MIdle:  if (cmd == 2) begin m_run = 0; m_ovf = 0; m_state = MRun; end
            MRun: begin
                if (cmd == 1) model_clear();
                else if (cmd == 3) m_state = MPause;
                else if (cmd == 4) m_lap = !m_lap;
            end
            MPause: begin
                if (cmd == 1) model_clear();
                else if ((cmd == 2 || cmd == 3) && !m_ovf) m_state = MRun;
                else if (cmd == 4 && m_lap) m_lap = 0;
            end
            default: ;
        endcase
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) model_reset();
        else model_step();
    end

    function automatic logic [5:0] dig(input logic en, input int v, input logic dp);
        logic [3:0] b;
        b = 4'(v);
        return {en, b, dp};
    endfunction

    function automatic logic [71:0] exp_vec();
        int e, smn, ssc, scs;
        logic en8;
        e = elapsed();
        smn = m_snap / 6000; ssc = (m_snap / 100) % 60; scs = m_snap % 100;
`ifdef LEADING_ZERO_BLANK_EN
        en8 = (smn / 10) != 0;
`else
        en8 = 1'b1;
`endif
        return {m_state == MRun, m_lap, m_ovf, 7'(e / 6000), 7'((e / 100) % 60), 7'(e % 100),
                dig(en8, smn / 10, 0), dig(1, smn % 10, 1), dig(1, ssc / 10, 0),
                dig(1, ssc % 10, 1), dig(1, scs / 10, 0), dig(1, scs % 10, 0), 6'b0, 6'b0};
    endfunction

    function automatic logic [71:0] obs_vec();
        return {running, lap_hold, ovf, min_out, sec_out, cs_out, d8, d7, d6, d5, d4, d3, d2, d1};
    endfunction

    task automatic test_reset();
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        total++; if (obs_vec() !== exp_vec()) begin bad++;
            $display("FAIL reset_vec: got %h expected %h", obs_vec(), exp_vec()); end
        total++; if ({d7, d3, d2, d1, running} !== {6'b100001, 6'b100000, 12'b0, 1'b0}) begin bad++;
            $display("FAIL reset_digits: got d7=%b d3=%b d2=%b d1=%b run=%b", d7, d3, d2, d1, running); end
        reset = 1'b1;
        @(negedge clock);
        total++; if (obs_vec() !== exp_vec()) begin bad++;
            $display("FAIL reset_release: got %h expected %h", obs_vec(), exp_vec()); end
    endtask

    task automatic test_count();
        start = 1'b1; @(negedge clock); start = 1'b0;
        total++; if (running !== 1'b1) begin bad++;
            $display("FAIL count_running: got %b expected 1", running); end
        repeat (3) @(negedge clock);
        total++; if (cs_out !== 7'd0) begin bad++;
            $display("FAIL count_cs0: got %0d expected 0", cs_out); end
        @(negedge clock);
        total++; if (cs_out !== 7'd1 || obs_vec() !== exp_vec()) begin bad++;
            $display("FAIL count_cs1: got cs=%0d vec=%h expected cs=1 vec=%h", cs_out, obs_vec(), exp_vec()); end
        repeat (96) @(negedge clock);
        total++; if (cs_out !== 7'd25) begin bad++;
            $display("FAIL count_cs25: got %0d expected 25", cs_out); end
        @(negedge clock);
        total++; if (d4 !== 6'b100100 || d3 !== 6'b101010) begin bad++;
            $display("FAIL count_digits: got d4=%b d3=%b expected 100100 101010", d4, d3); end
    endtask

    task automatic test_carry();
        int n = 0;
        while (elapsed() != 6000 && n < 30000) begin @(negedge clock); n++; end
        total++; if (n >= 30000) begin bad++;
            $display("FAIL carry_timeout: got %0d cycles expected under 30000", n); end
        total++; if (min_out !== 7'd1 || sec_out !== 7'd0 || cs_out !== 7'd0) begin bad++;
            $display("FAIL carry_count: got %0d:%0d.%0d expected 1:0.0", min_out, sec_out, cs_out); end
        @(negedge clock);
        total++; if (d7 !== 6'b100011 || obs_vec() !== exp_vec()) begin bad++;
            $display("FAIL carry_d7: got d7=%b vec=%h expected d7=100011 vec=%h", d7, obs_vec(), exp_vec()); end
    endtask

    task automatic test_pause();
        int n = 0;
        int held;
        while (!(m_state == MRun && (m_run % TICK) == 1) && n < 20) begin @(negedge clock); n++; end
        pause = 1'b1; @(negedge clock); pause = 1'b0;
        held = int'(cs_out);
        total++; if (running !== 1'b0 || cs_out !== 7'(elapsed() % 100)) begin bad++;
            $display("FAIL pause_enter: got run=%b cs=%0d expected run=0 cs=%0d", running, cs_out, elapsed() % 100); end
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            total++; if (cs_out !== 7'(held)) begin bad++;
                $display("FAIL pause_hold: got %0d expected %0d", cs_out, held); end
        end
        start = 1'b1; @(negedge clock); start = 1'b0;
        total++; if (running !== 1'b1 || cs_out !== 7'(held)) begin bad++;
            $display("FAIL pause_resume: got run=%b cs=%0d expected run=1 cs=%0d", running, cs_out, held); end
        @(negedge clock);
        total++; if (cs_out !== 7'(held)) begin bad++;
            $display("FAIL pause_tick1: got %0d expected %0d", cs_out, held); end
        @(negedge clock);
        total++; if (cs_out !== 7'((held + 1) % 100) || obs_vec() !== exp_vec()) begin bad++;
            $display("FAIL pause_tick2: got %0d expected %0d", cs_out, (held + 1) % 100); end
    endtask

    task automatic test_lap();
        int n = 0;
        while ((elapsed() % 100) != 10 && n < 500) begin @(negedge clock); n++; end
        lap = 1'b1; @(negedge clock); lap = 1'b0;
        total++; if (lap_hold !== 1'b1) begin bad++;
            $display("FAIL lap_on: got %b expected 1", lap_hold); end
        n = 0;
        while ((elapsed() % 100) != 30 && n < 200) begin
            @(negedge clock); n++;
            total++; if (d4 !== 6'b100010 || d3 !== 6'b100000) begin bad++;
                $display("FAIL lap_frozen: got d4=%b d3=%b expected 100010 100000", d4, d3); end
        end
        total++; if (cs_out !== 7'd30) begin bad++;
            $display("FAIL lap_live: got %0d expected 30", cs_out); end
        lap = 1'b1; @(negedge clock); lap = 1'b0;
        total++; if (lap_hold !== 1'b0) begin bad++;
            $display("FAIL lap_off: got %b expected 0", lap_hold); end
        @(negedge clock);
        total++; if (obs_vec() !== exp_vec()) begin bad++;
            $display("FAIL lap_follow: got %h expected %h", obs_vec(), exp_vec()); end
    endtask

    task automatic test_simultaneous();
        stop = 1'b1; pause = 1'b1; @(negedge clock); stop = 1'b0; pause = 1'b0;
        total++; if (running !== 1'b0 || {min_out, sec_out, cs_out} !== 21'd0) begin bad++;
            $display("FAIL simul_stop: got run=%b %0d:%0d.%0d expected idle 0:0.0", running, min_out, sec_out, cs_out); end
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            total++; if (running !== 1'b1 || obs_vec() !== exp_vec()) begin bad++;
                $display("FAIL hold_start: got %h expected %h", obs_vec(), exp_vec()); end
        end
        start = 1'b0;
        pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            total++; if (running !== 1'b0) begin bad++;
                $display("FAIL hold_pause: got run=%b expected 0", running); end
        end
        pause = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_saturation();
        int n = 0;
        force dut.min_q = 7'd99;
        force dut.sec_q = 7'd59;
        force dut.cs_q  = 7'd97;
        m_run = longint'(599997) * TICK + (m_run % TICK);
        @(negedge clock);
        release dut.min_q;
        release dut.sec_q;
        release dut.cs_q;
        total++; if (obs_vec() !== exp_vec()) begin bad++;
            $display("FAIL sat_preload: got %h expected %h", obs_vec(), exp_vec()); end
        start = 1'b1; @(negedge clock); start = 1'b0;
        while (!m_ovf && n < 100) begin @(negedge clock); n++; end
        total++; if (ovf !== 1'b1 || running !== 1'b0 || {min_out, sec_out, cs_out} !== {7'd99, 7'd59, 7'd99}) begin bad++;
            $display("FAIL sat_hit: got ovf=%b run=%b %0d:%0d.%0d expected ovf=1 run=0 99:59.99",
                     ovf, running, min_out, sec_out, cs_out); end
        repeat (10) @(negedge clock);
        start = 1'b1; @(negedge clock); start = 1'b0;
        total++; if (running !== 1'b0 || cs_out !== 7'd99 || obs_vec() !== exp_vec()) begin bad++;
            $display("FAIL sat_start_ignored: got %h expected %h", obs_vec(), exp_vec()); end
        stop = 1'b1; @(negedge clock); stop = 1'b0;
        @(negedge clock);
        total++; if (ovf !== 1'b0 || {min_out, sec_out, cs_out} !== 21'd0 || d3 !== 6'b100000
                     || obs_vec() !== exp_vec()) begin bad++;
            $display("FAIL sat_stop: got %h expected %h", obs_vec(), exp_vec()); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            total++; if (obs_vec() !== exp_vec()) begin bad++;
                $display("FAIL random_%0d: got %h expected %h", i, obs_vec(), exp_vec()); end
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 15) == 0);
            pause = ($urandom_range(0, 7) == 0);
            lap   = ($urandom_range(0, 7) == 0);
        end
        start = 1'b0; stop = 1'b0; pause = 1'b0; lap = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset_midrun();
        stop = 1'b1; @(negedge clock); stop = 1'b0; @(negedge clock);
        start = 1'b1; @(negedge clock); start = 1'b0;
        repeat (30) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        total++; if (running !== 1'b0 || cs_out !== 7'd0 || d3 !== 6'b100000 || obs_vec() !== exp_vec()) begin bad++;
            $display("FAIL reset_async: got %h expected %h", obs_vec(), exp_vec()); end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_count();
        test_carry();
        test_pause();
        test_lap();
        test_simultaneous();
        test_saturation();
        test_random();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
